// File: rtl/we_regfile_pkg.sv
// we_regfile_pkg: shared constants and the byte-strobe merge helper used by
// both the storage registers and the optional write-first read bypass.
package we_regfile_pkg;

  localparam int WE_REGFILE_WIDTH = 32;
  localparam int WE_REGFILE_DEPTH = 8;

  // Widest word the merge helper handles; callers cast their own width in/out.
  localparam int MERGE_MAX_W = 256;
  localparam int MERGE_MAX_STRB_W = MERGE_MAX_W / 8;

  // Lanes with a set strobe bit take new_val, the others keep old_val.
  function automatic logic [MERGE_MAX_W-1:0] strb_merge(
    input logic [MERGE_MAX_W-1:0]      old_val,
    input logic [MERGE_MAX_W-1:0]      new_val,
    input logic [MERGE_MAX_STRB_W-1:0] strb
  );
    logic [MERGE_MAX_W-1:0] res;
    res = '0;
    for (int i = 0; i < MERGE_MAX_STRB_W; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/we_regfile_byte_we_reg.sv
// byte_we_reg: one WIDTH-bit register with per-byte write enables and an
// asynchronous active-high reset to RESET_VAL.
module byte_we_reg
  import we_regfile_pkg::*;
#(
  parameter int                 WIDTH     = WE_REGFILE_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int                STRB_W    = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_in,
  input  logic [STRB_W-1:0] strb_in,
  input  logic [WIDTH-1:0]  d_in,
  output logic [WIDTH-1:0]  q_out
);

  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] val_d;

  // Next value: strobed lanes from d_in when selected, otherwise hold.
  always_comb begin
    val_d = val_q;
    if (we_in) begin
      val_d = WIDTH'(strb_merge(MERGE_MAX_W'(val_q), MERGE_MAX_W'(d_in),
                                MERGE_MAX_STRB_W'(strb_in)));
    end else begin
      val_d = val_q;
    end
  end

  // Storage flop with asynchronous reset to the configured reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= RESET_VAL;
    end else begin
      val_q <= val_d;
    end
  end

  assign q_out = val_q;

endmodule

// File: rtl/we_regfile.sv
// we_regfile: DEPTH x WIDTH register bank, one byte-strobed write port, two
// registered read ports (1-cycle latency) and an out-of-range error pulse.
// Build option: define WE_REGFILE_BYPASS_EN for write-first reads on a
// same-cycle same-address collision; default build is read-first.
module we_regfile
  import we_regfile_pkg::*;
#(
  parameter int               WIDTH     = WE_REGFILE_WIDTH,
  parameter int               DEPTH     = WE_REGFILE_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              ADDR_W    = $clog2(DEPTH),
  localparam int              STRB_W    = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_in,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [WIDTH-1:0]  rd0_data,
  output logic              rd0_valid,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [WIDTH-1:0]  rd1_data,
  output logic              rd1_valid,
  output logic              err_out
);

  // One extra bit so DEPTH itself is representable for the range compare.
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0] bank_s [DEPTH];
  logic [DEPTH-1:0] wr_sel_s;
  logic             wr_ok_s;
  logic             rd0_ok_s;
  logic             rd1_ok_s;
  logic [WIDTH-1:0] rd0_sel_s;
  logic [WIDTH-1:0] rd1_sel_s;
  logic [WIDTH-1:0] rd0_word_s;
  logic [WIDTH-1:0] rd1_word_s;

  logic [WIDTH-1:0] rd0_data_q,  rd0_data_d;
  logic [WIDTH-1:0] rd1_data_q,  rd1_data_d;
  logic             rd0_valid_q, rd0_valid_d;
  logic             rd1_valid_q, rd1_valid_d;
  logic             err_q,       err_d;

  // Range checks and per-register write select decode.
  always_comb begin
    wr_ok_s  = wr_in & ({1'b0, wr_addr} < DEPTH_L);
    rd0_ok_s = ({1'b0, rd0_addr} < DEPTH_L);
    rd1_ok_s = ({1'b0, rd1_addr} < DEPTH_L);
    wr_sel_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_sel_s[i] = wr_ok_s & (wr_addr == ADDR_W'(i));
    end
  end

  // Storage: DEPTH byte-enabled registers.
  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    byte_we_reg #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_reg (
      .clk     (clk),
      .rst     (rst),
      .we_in   (wr_sel_s[g]),
      .strb_in (wr_strb),
      .d_in    (wr_data),
      .q_out   (bank_s[g])
    );
  end

  // Read muxes; out-of-range addresses read as zero.
  always_comb begin
    rd0_sel_s = '0;
    rd1_sel_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd0_sel_s = (rd0_addr == ADDR_W'(i)) ? bank_s[i] : rd0_sel_s;
      rd1_sel_s = (rd1_addr == ADDR_W'(i)) ? bank_s[i] : rd1_sel_s;
    end
    rd0_word_s = rd0_ok_s ? rd0_sel_s : '0;
    rd1_word_s = rd1_ok_s ? rd1_sel_s : '0;
`ifdef WE_REGFILE_BYPASS_EN
    // Write-first: a colliding in-range write is merged into the read word.
    rd0_word_s = (wr_ok_s && rd0_ok_s && (rd0_addr == wr_addr)) ?
                 WIDTH'(strb_merge(MERGE_MAX_W'(rd0_word_s), MERGE_MAX_W'(wr_data),
                                   MERGE_MAX_STRB_W'(wr_strb))) : rd0_word_s;
    rd1_word_s = (wr_ok_s && rd1_ok_s && (rd1_addr == wr_addr)) ?
                 WIDTH'(strb_merge(MERGE_MAX_W'(rd1_word_s), MERGE_MAX_W'(wr_data),
                                   MERGE_MAX_STRB_W'(wr_strb))) : rd1_word_s;
`else
    // Read-first: the read sees the contents before this cycle's write.
    rd0_word_s = rd0_word_s;
    rd1_word_s = rd1_word_s;
`endif
  end

  // Output next-state: data holds when idle, valid and error are one-shot.
  always_comb begin
    rd0_data_d  = rd0_en ? rd0_word_s : rd0_data_q;
    rd1_data_d  = rd1_en ? rd1_word_s : rd1_data_q;
    rd0_valid_d = rd0_en;
    rd1_valid_d = rd1_en;
    err_d       = (wr_in & ~wr_ok_s) | (rd0_en & ~rd0_ok_s) | (rd1_en & ~rd1_ok_s);
  end

  // Registered outputs with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd0_data_q  <= '0;
      rd1_data_q  <= '0;
      rd0_valid_q <= 1'b0;
      rd1_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rd0_data_q  <= rd0_data_d;
      rd1_data_q  <= rd1_data_d;
      rd0_valid_q <= rd0_valid_d;
      rd1_valid_q <= rd1_valid_d;
      err_q       <= err_d;
    end
  end

  assign rd0_data  = rd0_data_q;
  assign rd1_data  = rd1_data_q;
  assign rd0_valid = rd0_valid_q;
  assign rd1_valid = rd1_valid_q;
  assign err_out   = err_q;

endmodule
